fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC and issues instruction-memory reads.
- Holds fetched words in a one-entry skid buffer while the pipeline is stalled.
- Presents instr_id, npc_id, rs_id and rt_id to decode and to the hazard unit, and consumes the hazard unit's stall/flush plus EX-stage redirects.

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, issues instruction-memory reads, parks one fetched word in a
// skid buffer while decode is stalled, and freezes on HALT until reset.
// Optional build macro FETCH_PERF_EN adds saturating fetch_cnt/stall_cnt
// performance counters; without it those ports do not exist.
module fetch_stage #(
    parameter int                WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_en,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt_id,
    output logic [WORD_W-1:0] instr_id,
    output logic [WORD_W-1:0] npc_id,
    output logic              valid_id,
    output logic [4:0]        rs_id,
    output logic [4:0]        rt_id,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetchState_t;

    fetchState_t       state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pcPlus4;
    logic [WORD_W-1:0] bufInstr;
    logic [WORD_W-1:0] bufNpc;
    logic              bufValid;
    logic              captureEn;

    // pc+4 wraps naturally at the word width
    assign pcPlus4   = pc + PC_STEP;
    // a returning word can only be accepted while the buffer is empty
    assign captureEn = ihit && !bufValid;

    // no new request while a parked word is waiting to drain
    assign imemREN  = (state == RUN) && !bufValid;
    assign imemaddr = pc;

    // register-file addresses for decode and hazard detection
    assign rs_id = instr_id[25:21];
    assign rt_id = instr_id[20:16];

    // fetch control FSM, PC, skid buffer and IF/ID register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RUN;
            halted   <= 1'b0;
            pc       <= PC_INIT;
            bufValid <= 1'b0;
            bufInstr <= '0;
            bufNpc   <= '0;
            instr_id <= '0;
            npc_id   <= '0;
            valid_id <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_en) begin
                        // wrong-path work (including a HALT in decode) is dropped
                        pc       <= redirect_pc;
                        bufValid <= 1'b0;
                        instr_id <= '0;
                        npc_id   <= '0;
                        valid_id <= 1'b0;
                    end else if (halt_id) begin
                        state    <= HALTED;
                        halted   <= 1'b1;
                        bufValid <= 1'b0;
                        instr_id <= '0;
                        npc_id   <= '0;
                        valid_id <= 1'b0;
                    end else if (flush || stall) begin
                        // flush bubbles IF/ID even when stalled; stall alone holds it
                        if (flush) begin
                            instr_id <= '0;
                            npc_id   <= '0;
                            valid_id <= 1'b0;
                        end
                        if (captureEn) begin
                            bufInstr <= iload;
                            bufNpc   <= pcPlus4;
                            bufValid <= 1'b1;
                            pc       <= pcPlus4;
                        end
                    end else if (bufValid) begin
                        instr_id <= bufInstr;
                        npc_id   <= bufNpc;
                        valid_id <= 1'b1;
                        bufValid <= 1'b0;
                    end else if (ihit) begin
                        instr_id <= iload;
                        npc_id   <= pcPlus4;
                        valid_id <= 1'b1;
                        pc       <= pcPlus4;
                    end else begin
                        instr_id <= '0;
                        npc_id   <= '0;
                        valid_id <= 1'b0;
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic loadValid;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // IF/ID receives a real instruction from the buffer or straight from memory
    assign loadValid = !redirect_en && !halt_id && !flush && !stall && (bufValid || ihit);

    // saturating performance counters, frozen once halted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else if (state == RUN) begin
            if (loadValid) begin
                fetch_cnt <= satInc(fetch_cnt);
            end
            if (stall) begin
                stall_cnt <= satInc(stall_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table plus randomized run against a queue-based
// reference model of the fetch stage.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt_id;
    logic [31:0] instr_id;
    logic [31:0] npc_id;
    logic        valid_id;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    always #5 CLK = ~CLK;

    fetch_stage dut (
`ifdef FETCH_PERF_EN
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .iload      (iload),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .stall      (stall),
        .flush      (flush),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .halt_id    (halt_id),
        .instr_id   (instr_id),
        .npc_id     (npc_id),
        .valid_id   (valid_id),
        .rs_id      (rs_id),
        .rt_id      (rt_id),
        .halted     (halted)
    );

    int nVec  = 0;
    int nFail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ih, input logic [31:0] ld, input logic st, input logic fl,
                         input logic rd, input logic [31:0] rp, input logic hl);
        ihit        = ih;
        iload       = ld;
        stall       = st;
        flush       = fl;
        redirect_en = rd;
        redirect_pc = rp;
        halt_id     = hl;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ih;
        logic [31:0] ld;
        logic        st;
        logic        fl;
        logic        rd;
        logic [31:0] rp;
        logic        hl;
        logic        expRen;
        logic [31:0] expInstr;
        logic [31:0] expNpc;
        logic        expValid;
        logic [31:0] expPc;
        logic        expHalted;
    } vec_t;

    function automatic vec_t mk(input logic ih, input logic [31:0] ld, input logic st, input logic fl,
                                input logic rd, input logic [31:0] rp, input logic hl,
                                input logic eRen, input logic [31:0] eInstr, input logic [31:0] eNpc,
                                input logic eValid, input logic [31:0] ePc, input logic eHalt);
        vec_t v;
        v.ih = ih; v.ld = ld; v.st = st; v.fl = fl; v.rd = rd; v.rp = rp; v.hl = hl;
        v.expRen = eRen; v.expInstr = eInstr; v.expNpc = eNpc; v.expValid = eValid;
        v.expPc = ePc; v.expHalted = eHalt;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } word_t;

    word_t       skidQ[$];
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mNpc;
    logic        mValid;
    logic        mHalted;
`ifdef FETCH_PERF_EN
    logic [31:0] mFetch;
    logic [31:0] mStall;
`endif

    task automatic modelReset();
        mPc     = 32'h0;
        skidQ.delete();
        mInstr  = 32'h0;
        mNpc    = 32'h0;
        mValid  = 1'b0;
        mHalted = 1'b0;
`ifdef FETCH_PERF_EN
        mFetch  = 32'h0;
        mStall  = 32'h0;
`endif
    endtask

    task automatic modelClear();
        mInstr = 32'h0;
        mNpc   = 32'h0;
        mValid = 1'b0;
    endtask

    task automatic modelStep(input logic ih, input logic [31:0] ld, input logic st, input logic fl,
                             input logic rd, input logic [31:0] rp, input logic hl);
        word_t arriving;
        word_t w;
        logic  accepted;
        if (mHalted) return;
`ifdef FETCH_PERF_EN
        if (st && mStall != 32'hFFFF_FFFF) mStall++;
`endif
        accepted = ih && (skidQ.size() == 0);
        arriving = {ld, mPc + 32'd4};
        if (rd) begin
            mPc = rp;
            skidQ.delete();
            modelClear();
        end else if (hl) begin
            mHalted = 1'b1;
            skidQ.delete();
            modelClear();
        end else if (fl || st) begin
            if (fl) modelClear();
            if (accepted) begin
                skidQ.push_back(arriving);
                mPc = mPc + 32'd4;
            end
        end else if (skidQ.size() != 0) begin
            w      = skidQ.pop_front();
            mInstr = w.instr;
            mNpc   = w.npc;
            mValid = 1'b1;
`ifdef FETCH_PERF_EN
            if (mFetch != 32'hFFFF_FFFF) mFetch++;
`endif
        end else if (accepted) begin
            mInstr = arriving.instr;
            mNpc   = arriving.npc;
            mValid = 1'b1;
            mPc    = mPc + 32'd4;
`ifdef FETCH_PERF_EN
            if (mFetch != 32'hFFFF_FFFF) mFetch++;
`endif
        end else begin
            modelClear();
        end
    endtask

    task automatic checkModel(input string tag);
        check({tag, " instr_id"}, instr_id, mInstr);
        check({tag, " npc_id"}, npc_id, mNpc);
        check({tag, " valid_id"}, {31'b0, valid_id}, {31'b0, mValid});
        check({tag, " imemaddr"}, imemaddr, mPc);
        check({tag, " halted"}, {31'b0, halted}, {31'b0, mHalted});
        check({tag, " rs_id"}, {27'b0, rs_id}, {27'b0, mInstr[25:21]});
        check({tag, " rt_id"}, {27'b0, rt_id}, {27'b0, mInstr[20:16]});
`ifdef FETCH_PERF_EN
        check({tag, " fetch_cnt"}, fetch_cnt, mFetch);
        check({tag, " stall_cnt"}, stall_cnt, mStall);
`endif
    endtask

    // ---------------- test sequence ----------------
    vec_t        tbl[$];
    logic [31:0] W0, W8, WC, W10, W40, W100, W104, WFC;
    int          haltCnt;
    logic        ih, st, fl, rd, hl;
    logic [31:0] ld, rp;

    initial begin
        W0 = 32'h2021_0001; W8 = 32'hAAAA_0008; WC = 32'h8C43_000C; W10 = 32'h1234_5678;
        W40 = 32'h0108_4020; W100 = 32'h03E0_0008; W104 = 32'hAC85_0004; WFC = 32'h1111_2222;

        //        ih ld    st fl rd rp            hl  ren instr npc          vld pc            halt
        tbl.push_back(mk(1, W0,   0, 0, 0, 32'h0,        0,  1, W0,   32'h4,   1, 32'h4,   0));
        tbl.push_back(mk(1, W0,   0, 0, 0, 32'h0,        0,  1, W0,   32'h8,   1, 32'h8,   0));
        tbl.push_back(mk(1, W8,   1, 0, 0, 32'h0,        0,  1, W0,   32'h8,   1, 32'hC,   0));
        tbl.push_back(mk(0, 32'h0,1, 0, 0, 32'h0,        0,  0, W0,   32'h8,   1, 32'hC,   0));
        tbl.push_back(mk(0, 32'h0,1, 0, 0, 32'h0,        0,  0, W0,   32'h8,   1, 32'hC,   0));
        tbl.push_back(mk(0, 32'h0,0, 0, 0, 32'h0,        0,  0, W8,   32'hC,   1, 32'hC,   0));
        tbl.push_back(mk(1, WC,   0, 0, 0, 32'h0,        0,  1, WC,   32'h10,  1, 32'h10,  0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0,   0,  1, 32'h0,32'h0,   0, 32'h10,  0));
        tbl.push_back(mk(1, W10,  1, 0, 0, 32'h0,        0,  1, 32'h0,32'h0,   0, 32'h14,  0));
        tbl.push_back(mk(1, W8,   1, 0, 1, 32'h40,       0,  0, 32'h0,32'h0,   0, 32'h40,  0));
        tbl.push_back(mk(1, W40,  0, 0, 0, 32'h0,        0,  1, W40,  32'h44,  1, 32'h44,  0));
        tbl.push_back(mk(0, 32'h0,0, 0, 1, 32'h100,      1,  1, 32'h0,32'h0,   0, 32'h100, 0));
        tbl.push_back(mk(1, W100, 0, 0, 0, 32'h0,        0,  1, W100, 32'h104, 1, 32'h104, 0));
        tbl.push_back(mk(1, W104, 1, 1, 0, 32'h0,        0,  1, 32'h0,32'h0,   0, 32'h108, 0));
        tbl.push_back(mk(0, 32'h0,0, 0, 0, 32'h0,        0,  0, W104, 32'h108, 1, 32'h108, 0));
        tbl.push_back(mk(0, 32'h0,0, 0, 1, 32'hFFFF_FFFC,0,  1, 32'h0,32'h0,   0, 32'hFFFF_FFFC, 0));
        tbl.push_back(mk(1, WFC,  0, 0, 0, 32'h0,        0,  1, WFC,  32'h0,   1, 32'h0,   0));
        tbl.push_back(mk(1, W8,   0, 0, 0, 32'h0,        1,  1, 32'h0,32'h0,   0, 32'h0,   1));

        // reset state
        RST = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 32'h0, 0);
        #1;
        check("rst imemaddr", imemaddr, 32'h0);
        check("rst imemREN", {31'b0, imemREN}, 32'h1);
        check("rst instr_id", instr_id, 32'h0);
        check("rst valid_id", {31'b0, valid_id}, 32'h0);
        check("rst halted", {31'b0, halted}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // directed table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ih, tbl[i].ld, tbl[i].st, tbl[i].fl, tbl[i].rd, tbl[i].rp, tbl[i].hl);
            #1;
            check($sformatf("v%0d imemREN", i), {31'b0, imemREN}, {31'b0, tbl[i].expRen});
            @(posedge CLK);
            #1;
            check($sformatf("v%0d instr_id", i), instr_id, tbl[i].expInstr);
            check($sformatf("v%0d npc_id", i), npc_id, tbl[i].expNpc);
            check($sformatf("v%0d valid_id", i), {31'b0, valid_id}, {31'b0, tbl[i].expValid});
            check($sformatf("v%0d pc", i), imemaddr, tbl[i].expPc);
            check($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, tbl[i].expHalted});
            check($sformatf("v%0d rs_id", i), {27'b0, rs_id}, {27'b0, tbl[i].expInstr[25:21]});
            check($sformatf("v%0d rt_id", i), {27'b0, rt_id}, {27'b0, tbl[i].expInstr[20:16]});
            @(negedge CLK);
        end

        // halted: frozen for 10 cycles even with redirect/flush/ihit presented
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'hDEAD_BEEF, i[0], 1, 1, 32'h80, 1);
            #1;
            check($sformatf("halt%0d imemREN", i), {31'b0, imemREN}, 32'h0);
            @(posedge CLK);
            #1;
            check($sformatf("halt%0d pc", i), imemaddr, 32'h0);
            check($sformatf("halt%0d valid_id", i), {31'b0, valid_id}, 32'h0);
            check($sformatf("halt%0d instr_id", i), instr_id, 32'h0);
            check($sformatf("halt%0d halted", i), {31'b0, halted}, 32'h1);
            @(negedge CLK);
        end

        // asynchronous reset while stalled with a full buffer
        RST = 1'b1;
        #1;
        RST = 1'b0;
        check("rst2 halted", {31'b0, halted}, 32'h0);
        drive(1, W0, 0, 0, 0, 32'h0, 0);
        @(posedge CLK); #1; @(negedge CLK);
        drive(1, W8, 1, 0, 0, 32'h0, 0);
        @(posedge CLK); #1;
        check("pre-rst imemREN", {31'b0, imemREN}, 32'h0);
        check("pre-rst pc", imemaddr, 32'h8);
        check("pre-rst instr_id", instr_id, W0);
`ifdef FETCH_PERF_EN
        check("pre-rst fetch_cnt", fetch_cnt, 32'h1);
        check("pre-rst stall_cnt", stall_cnt, 32'h1);
`endif
        @(negedge CLK);
        drive(0, 32'h0, 1, 0, 0, 32'h0, 0);
        #2;
        RST = 1'b1;
        #1;
        check("async-rst pc", imemaddr, 32'h0);
        check("async-rst imemREN", {31'b0, imemREN}, 32'h1);
        check("async-rst instr_id", instr_id, 32'h0);
        check("async-rst npc_id", npc_id, 32'h0);
        check("async-rst valid_id", {31'b0, valid_id}, 32'h0);
`ifdef FETCH_PERF_EN
        check("async-rst fetch_cnt", fetch_cnt, 32'h0);
        check("async-rst stall_cnt", stall_cnt, 32'h0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        modelReset();

        // randomized run against the reference model
        haltCnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (mHalted) haltCnt++;
            if (haltCnt > 3) begin
                haltCnt = 0;
                RST = 1'b1;
                #1;
                modelReset();
                checkModel("rnd-rst");
                RST = 1'b0;
            end
            st = ($urandom % 10) < 3;
            fl = ($urandom % 10) == 0;
            rd = ($urandom % 20) == 0;
            rp = $urandom & 32'hFFFF_FFFC;
            hl = ($urandom % 60) == 0;
            ih = !mHalted && (skidQ.size() == 0) && (($urandom % 10) < 7);
            ld = $urandom;
            drive(ih, ld, st, fl, rd, rp, hl);
            #1;
            check($sformatf("r%0d imemREN", cyc), {31'b0, imemREN},
                  {31'b0, !mHalted && (skidQ.size() == 0)});
            modelStep(ih, ld, st, fl, rd, rp, hl);
            @(posedge CLK);
            #1;
            checkModel($sformatf("r%0d", cyc));
            @(negedge CLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
